// File: rtl/fix2float_pkg.sv
// Shared definitions for the fixed-point to float converter family:
// float format defaults and elaboration-time helper functions.
package fix2float_pkg;

    // Common output formats (exponent / stored mantissa widths)
    localparam int FMT_SINGLE_EXP_W = 8;
    localparam int FMT_SINGLE_MAN_W = 23;
    localparam int FMT_HALF_EXP_W   = 5;
    localparam int FMT_HALF_MAN_W   = 10;

    // Ceiling log2; returns the number of bits needed to index 'value' items
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Exponent bias for a given exponent width
    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Reserved all-ones exponent (infinity/NaN code)
    function automatic int exp_max(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Packed result width {sign, exponent, mantissa}
    function automatic int out_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

endpackage

// File: rtl/fix2float_lod.sv
// Leading-one detector: reports the index of the most significant set bit
// of 'value' and flags an all-zero input. Purely combinational.
module fix2float_lod
    import fix2float_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int POS_W = clog2(IN_W)
) (
    input  logic [IN_W-1:0]  value,
    output logic [POS_W-1:0] pos,
    output logic             zero
);

    // Scan upward so the highest set bit wins
    always_comb begin
        pos  = '0;
        zero = 1'b1;
        for (int i = 0; i < IN_W; i++) begin
            if (value[i]) begin
                pos  = POS_W'(i);
                zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fix2float_param_pipe.sv
// Three-stage fixed-point to IEEE-754-style float converter with
// valid/ready handshaking, round-to-nearest-even and saturation flags.
// S1 takes sign/magnitude, S2 finds the leading one, S3 normalises,
// rounds and packs into the output registers.
module fix2float_param_pipe
    import fix2float_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int FRAC_W = 8,
    parameter int SIGNED = 0,
    parameter int EXP_W  = FMT_SINGLE_EXP_W,
    parameter int MAN_W  = FMT_SINGLE_MAN_W
) (
    input  logic                   aclk,
    input  logic                   rstn,
    input  logic                   clken,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [IN_W-1:0]        s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [EXP_W+MAN_W:0]   m_data,
    output logic                   m_ovf,
    output logic                   m_unf,
    output logic                   m_inexact
);

    localparam int OUT_W = out_w(EXP_W, MAN_W);
    localparam int POS_W = clog2(IN_W);
    localparam int BIAS  = bias(EXP_W);
    localparam int EMAX  = exp_max(EXP_W);
    // Normalised magnitude followed by room for mantissa, guard and sticky
    localparam int EXT_W = IN_W + MAN_W + 2;

    // Stage 1 registers
    logic              v1;
    logic              sign1;
    logic [IN_W-1:0]   mag1;
    // Stage 2 registers
    logic              v2;
    logic              sign2;
    logic [IN_W-1:0]   mag2;
    logic [POS_W-1:0]  pos2;
    logic              zero2;

    // Handshake chain: a stage may load when it is empty or its successor moves
    logic rdy2;
    logic rdy3;
    logic ld1;
    logic ld2;
    logic ld3;

    assign rdy3    = !m_valid | m_ready;
    assign rdy2    = !v2 | rdy3;
    assign s_ready = !v1 | rdy2;
    assign ld1     = clken & s_ready;
    assign ld2     = clken & rdy2;
    assign ld3     = clken & rdy3;

    // Sign and magnitude of the incoming sample; |most-negative| fits in IN_W bits
    logic            in_sign;
    logic [IN_W-1:0] in_mag;

    // Split the input into sign and unsigned magnitude
    always_comb begin
        in_sign = 1'b0;
        in_mag  = s_data;
        if (SIGNED != 0 && s_data[IN_W-1]) begin
            in_sign = 1'b1;
            in_mag  = ~s_data + IN_W'(1);
        end
    end

    // S1: capture sign and magnitude
    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            v1    <= 1'b0;
            sign1 <= 1'b0;
            mag1  <= '0;
        end else if (ld1) begin
            v1 <= s_valid;
            if (s_valid) begin
                sign1 <= in_sign;
                mag1  <= in_mag;
            end
        end
    end

    logic [POS_W-1:0] lod_pos;
    logic             lod_zero;

    fix2float_lod #(
        .IN_W  (IN_W),
        .POS_W (POS_W)
    ) u_lod (
        .value (mag1),
        .pos   (lod_pos),
        .zero  (lod_zero)
    );

    // S2: register leading-one position alongside the magnitude
    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            v2    <= 1'b0;
            sign2 <= 1'b0;
            mag2  <= '0;
            pos2  <= '0;
            zero2 <= 1'b1;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                sign2 <= sign1;
                mag2  <= mag1;
                pos2  <= lod_pos;
                zero2 <= lod_zero;
            end
        end
    end

    // S3 combinational datapath
    logic [POS_W-1:0]  shift_amt;
    logic [IN_W-1:0]   norm;
    logic [EXT_W-1:0]  frac_ext;
    logic [MAN_W:0]    sig;        // hidden one plus stored mantissa
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [MAN_W+1:0]  sig_sum;
    logic              carry;
    logic [MAN_W-1:0]  mant_fin;
    int                exp_val;
    logic [OUT_W-1:0]  res_data;
    logic              res_ovf;
    logic              res_unf;
    logic              res_inx;

    // Normalise, round to nearest even, then saturate or flush at the range limits
    always_comb begin
        shift_amt = POS_W'(IN_W - 1) - pos2;
        norm      = mag2 << shift_amt;
        frac_ext  = {norm, {(MAN_W + 2){1'b0}}};
        sig       = frac_ext[EXT_W-1 -: MAN_W+1];
        guard     = frac_ext[EXT_W-2-MAN_W];
        sticky    = |frac_ext[EXT_W-3-MAN_W:0];
        round_up  = guard & (sticky | sig[0]);
        sig_sum   = {1'b0, sig} + (MAN_W + 2)'(round_up);
        // Rounding past 1.11..1 yields 10.00..0: mantissa becomes zero, exponent +1
        carry     = sig_sum[MAN_W+1];
        mant_fin  = carry ? sig_sum[MAN_W:1] : sig_sum[MAN_W-1:0];
        exp_val   = BIAS + int'(pos2) - FRAC_W + int'(carry);

        res_data  = {sign2, exp_val[EXP_W-1:0], mant_fin};
        res_ovf   = 1'b0;
        res_unf   = 1'b0;
        res_inx   = guard | sticky;
        if (zero2) begin
            res_data = '0;
            res_inx  = 1'b0;
        end else if (exp_val >= EMAX) begin
            res_data = {sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            res_ovf  = 1'b1;
            res_inx  = 1'b1;
        end else if (exp_val <= 0) begin
            res_data = {sign2, {(EXP_W + MAN_W){1'b0}}};
            res_unf  = 1'b1;
            res_inx  = 1'b1;
        end
    end

    // S3: output registers, held while the consumer stalls
    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_ovf     <= 1'b0;
            m_unf     <= 1'b0;
            m_inexact <= 1'b0;
        end else if (ld3) begin
            m_valid <= v2;
            if (v2) begin
                m_data    <= res_data;
                m_ovf     <= res_ovf;
                m_unf     <= res_unf;
                m_inexact <= res_inx;
            end
        end
    end

endmodule

// File: tb/tb_fix2float_param_pipe.sv
// Bench for fix2float_param_pipe: four configurations (single unsigned,
// single signed, half integer, half Q0.16) share one stimulus stream.
// Expected results come from an independent integer model, with the
// directed reference values substituted for the configuration they target.
module tb_fix2float_param_pipe;

    logic        aclk = 1'b0;
    logic        rstn = 1'b0;
    logic        clken = 1'b1;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        m_ready = 1'b1;

    logic [3:0]       sr, mv, ovf, unf, inx;
    logic [31:0]      md0, md1;
    logic [15:0]      md2, md3;
    logic [3:0][31:0] od;
    logic [3:0][2:0]  of;

    assign od[0] = md0;
    assign od[1] = md1;
    assign od[2] = {16'h0, md2};
    assign od[3] = {16'h0, md3};
    assign of[0] = {ovf[0], unf[0], inx[0]};
    assign of[1] = {ovf[1], unf[1], inx[1]};
    assign of[2] = {ovf[2], unf[2], inx[2]};
    assign of[3] = {ovf[3], unf[3], inx[3]};

    always #5 aclk = ~aclk;

    fix2float_param_pipe #(.IN_W(16), .FRAC_W(8), .SIGNED(0), .EXP_W(8), .MAN_W(23)) u0 (
        .aclk(aclk), .rstn(rstn), .clken(clken), .s_valid(s_valid), .s_ready(sr[0]),
        .s_data(s_data), .m_valid(mv[0]), .m_ready(m_ready), .m_data(md0),
        .m_ovf(ovf[0]), .m_unf(unf[0]), .m_inexact(inx[0]));
    fix2float_param_pipe #(.IN_W(16), .FRAC_W(8), .SIGNED(1), .EXP_W(8), .MAN_W(23)) u1 (
        .aclk(aclk), .rstn(rstn), .clken(clken), .s_valid(s_valid), .s_ready(sr[1]),
        .s_data(s_data), .m_valid(mv[1]), .m_ready(m_ready), .m_data(md1),
        .m_ovf(ovf[1]), .m_unf(unf[1]), .m_inexact(inx[1]));
    fix2float_param_pipe #(.IN_W(16), .FRAC_W(0), .SIGNED(0), .EXP_W(5), .MAN_W(10)) u2 (
        .aclk(aclk), .rstn(rstn), .clken(clken), .s_valid(s_valid), .s_ready(sr[2]),
        .s_data(s_data), .m_valid(mv[2]), .m_ready(m_ready), .m_data(md2),
        .m_ovf(ovf[2]), .m_unf(unf[2]), .m_inexact(inx[2]));
    fix2float_param_pipe #(.IN_W(16), .FRAC_W(16), .SIGNED(0), .EXP_W(5), .MAN_W(10)) u3 (
        .aclk(aclk), .rstn(rstn), .clken(clken), .s_valid(s_valid), .s_ready(sr[3]),
        .s_data(s_data), .m_valid(mv[3]), .m_ready(m_ready), .m_data(md3),
        .m_ovf(ovf[3]), .m_unf(unf[3]), .m_inexact(inx[3]));

    int cfg_frac [4] = '{8, 8, 0, 16};
    int cfg_sgn  [4] = '{0, 1, 0, 0};
    int cfg_exp  [4] = '{8, 8, 5, 5};
    int cfg_man  [4] = '{23, 23, 10, 10};

    typedef struct {
        logic [15:0] x;
        int          di;     // configuration with a directed reference, -1 if none
        logic [31:0] dd;
        logic [2:0]  df;     // {ovf, unf, inexact}
    } stim_t;

    typedef struct {
        logic [3:0][31:0] d;
        logic [3:0][2:0]  f;
        int               cyc;
    } ent_t;

    stim_t pend [$];
    ent_t  sb [$];
    stim_t cur;

    int n_chk = 0;
    int n_pass = 0;
    int gcyc = 0;
    int acc_cnt = 0;
    int out_cnt = 0;
    bit lat_chk = 1'b0;
    bit tog_en = 1'b0;
    bit rnd_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    // Reference conversion: integer shift/remainder rounding, independent of pipeline structure
    function automatic void model(input logic [15:0] x, input int frac_w, input int sgn,
                                  input int exp_w, input int man_w,
                                  output logic [31:0] d, output logic [2:0] f);
        logic   s;
        longint mag, q, rem, half, mant, e, emax, sh;
        int     p;
        s    = (sgn != 0) && x[15];
        mag  = s ? (longint'(65536) - longint'(x)) : longint'(x);
        d    = '0;
        f    = '0;
        mant = 0;
        if (mag == 0) return;
        p = 0;
        for (int i = 0; i < 16; i++) if (mag[i]) p = i;
        if (p <= man_w) begin
            mant = (mag - (longint'(1) << p)) << (man_w - p);
        end else begin
            sh   = p - man_w;
            q    = mag >> sh;
            rem  = mag & ((longint'(1) << sh) - 1);
            half = longint'(1) << (sh - 1);
            if (rem != 0) f[0] = 1'b1;
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (longint'(1) << (man_w + 1))) begin
                q = q >> 1;
                p = p + 1;
            end
            mant = q - (longint'(1) << man_w);
        end
        e    = (longint'(1) << (exp_w - 1)) - 1 + p - frac_w;
        emax = (longint'(1) << exp_w) - 1;
        if (e >= emax) begin
            d = 32'((longint'(s) << (exp_w + man_w)) | (emax << man_w));
            f = 3'b101;
        end else if (e <= 0) begin
            d = 32'(longint'(s) << (exp_w + man_w));
            f = 3'b011;
        end else begin
            d = 32'((longint'(s) << (exp_w + man_w)) | (e << man_w) | mant);
        end
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer
    always @(negedge aclk) begin : mon
        ent_t        e;
        logic [31:0] d;
        logic [2:0]  f;
        if (rstn) begin
            if (s_valid && sr[0] && clken) begin
                for (int i = 0; i < 4; i++) begin
                    model(s_data, cfg_frac[i], cfg_sgn[i], cfg_exp[i], cfg_man[i], d, f);
                    e.d[i] = d;
                    e.f[i] = f;
                end
                if (cur.di >= 0) begin
                    e.d[cur.di] = cur.dd;
                    e.f[cur.di] = cur.df;
                end
                e.cyc = gcyc;
                sb.push_back(e);
                acc_cnt++;
                $display("in  x=%04h cyc=%0d", s_data, gcyc);
            end
            if (mv[0] && m_ready && clken) begin
                chk("sb_nonempty", 64'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    for (int i = 0; i < 4; i++) begin
                        chk($sformatf("dut%0d_valid", i), 64'(mv[i]), 1);
                        chk($sformatf("dut%0d_data", i), 64'(od[i]), 64'(e.d[i]));
                        chk($sformatf("dut%0d_flags", i), 64'(of[i]), 64'(e.f[i]));
                    end
                    if (lat_chk) chk("latency", 64'(gcyc - e.cyc), 3);
                    $display("out d0=%08h d1=%08h d2=%04h d3=%04h cyc=%0d", od[0], od[1], od[2][15:0], od[3][15:0], gcyc);
                end
                out_cnt++;
            end
            if (clken) gcyc++;
        end
    end

    task automatic load_next();
        if (pend.size() > 0) begin
            cur     = pend.pop_front();
            s_data  = cur.x;
            s_valid = 1'b1;
        end else begin
            s_valid = 1'b0;
        end
    endtask

    // One clock: observe handshake mid-cycle, then update inputs just after the edge
    task automatic step();
        bit acc;
        @(negedge aclk);
        acc = s_valid && sr[0] && clken && rstn;
        @(posedge aclk);
        #1;
        if (tog_en) clken = !clken;
        if (rnd_rdy) m_ready = ($urandom_range(0, 3) != 0);
        if (acc || !s_valid) load_next();
    endtask

    task automatic push(input logic [15:0] x, input int di, input logic [31:0] dd, input logic [2:0] df);
        stim_t s;
        s.x = x; s.di = di; s.dd = dd; s.df = df;
        pend.push_back(s);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((pend.size() > 0 || s_valid || sb.size() > 0) && n < budget) begin
            step();
            n++;
        end
        chk(tag, 64'(pend.size() + sb.size()), 0);
    endtask

    initial begin
        logic [31:0] hold;
        int a0, o0;
        cur.di = -1; cur.x = '0; cur.dd = '0; cur.df = '0;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_mvalid%0d", i), 64'(mv[i]), 0);
            chk($sformatf("rst_sready%0d", i), 64'(sr[i]), 1);
            chk($sformatf("rst_data%0d", i), 64'(od[i]), 0);
            chk($sformatf("rst_flags%0d", i), 64'(of[i]), 0);
        end
        rstn = 1'b1;

        // Single-precision Q8.8 unsigned, back-to-back, latency 3
        lat_chk = 1'b1;
        push(16'h0180, 0, 32'h3FC00000, 3'b000);
        push(16'h0000, 0, 32'h00000000, 3'b000);
        push(16'h0001, 0, 32'h3B800000, 3'b000);
        push(16'hFFFF, 0, 32'h437FFF00, 3'b000);
        // Signed Q8.8
        push(16'hFE80, 1, 32'hBFC00000, 3'b000);
        push(16'h8000, 1, 32'hC3000000, 3'b000);
        // Half precision, integer input: RNE ties and overflow
        push(16'h0801, 2, 32'h00006800, 3'b001);
        push(16'h0803, 2, 32'h00006802, 3'b001);
        push(16'hFFFF, 2, 32'h00007C00, 3'b101);
        // Half precision Q0.16: underflow
        push(16'h0001, 3, 32'h00000000, 3'b011);
        drain("directed_drain", 100);
        lat_chk = 1'b0;

        // Backpressure: 5 samples against a stalled consumer
        m_ready = 1'b0;
        a0 = acc_cnt;
        for (int i = 0; i < 5; i++) push(16'(16'h0100 + i * 16'h0123), -1, '0, '0);
        repeat (8) step();
        chk("bp_accepts", 64'(acc_cnt - a0), 3);
        chk("bp_s_ready", 64'(sr[0]), 0);
        hold = od[0];
        repeat (3) step();
        chk("bp_hold_data", 64'(od[0]), 64'(hold));
        chk("bp_hold_valid", 64'(mv[0]), 1);
        m_ready = 1'b1;
        o0 = out_cnt;
        repeat (5) step();
        chk("bp_burst", 64'(out_cnt - o0), 5);
        drain("bp_drain", 50);

        // Clock enable toggling, consumer always ready: latency counted in enabled cycles
        tog_en = 1'b1;
        lat_chk = 1'b1;
        for (int i = 0; i < 20; i++) push(16'($urandom), -1, '0, '0);
        drain("clken_drain", 400);
        lat_chk = 1'b0;

        // Clock enable toggling plus random consumer stalls
        rnd_rdy = 1'b1;
        for (int i = 0; i < 30; i++) push(16'($urandom), -1, '0, '0);
        drain("random_drain", 800);
        rnd_rdy = 1'b0;
        tog_en = 1'b0;
        clken = 1'b1;
        m_ready = 1'b1;

        // Reset in the middle of a burst
        for (int i = 0; i < 10; i++) push(16'($urandom), -1, '0, '0);
        repeat (6) step();
        rstn = 1'b0;
        #1;
        chk("midrst_mvalid", 64'(mv[0]), 0);
        chk("midrst_data", 64'(od[0]), 0);
        chk("midrst_sready", 64'(sr[0]), 1);
        pend.delete();
        sb.delete();
        s_valid = 1'b0;
        repeat (2) step();
        rstn = 1'b1;
        repeat (4) step();
        chk("post_rst_idle", 64'(mv[0]), 0);
        for (int i = 0; i < 6; i++) push(16'($urandom), -1, '0, '0);
        drain("post_rst_drain", 100);

        chk("sb_empty", 64'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
